// File: rtl/basys3_status_tx.sv
// ============================================================================
// basys3_status_tx : switch/button status encoder, 10-byte ASCII frame on a
// valid/ready stream.  Optional periodic resend: BASYS3_STATUS_REFRESH_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module basys3_status_tx #(
    parameter int SWITCH_COUNT = 16,
    parameter int BUTTON_COUNT = 5,
    parameter int DATA_WIDTH   = 8
`ifdef BASYS3_STATUS_REFRESH_EN
    ,
    parameter int REFRESH_CYCLES = 5_000_000
`endif
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    ena,
    input  logic [SWITCH_COUNT-1:0] switch_in,
    input  logic [BUTTON_COUNT-1:0] button_in,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy
);

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_SEND = 1'b1} state_t;

    localparam logic [3:0] c_LAST_IDX = 4'd9;

    state_t                  r_state, w_state_nxt;
    logic [SWITCH_COUNT-1:0] r_sw_s1, r_sw_s2, r_snap_sw, w_snap_sw_nxt;
    logic [BUTTON_COUNT-1:0] r_btn_s1, r_btn_s2, r_snap_btn, w_snap_btn_nxt;
    logic [3:0]              r_idx, w_idx_nxt;
    logic [DATA_WIDTH-1:0]   r_out_data, w_data_nxt;
    logic                    r_out_valid, w_valid_nxt;
    logic                    r_busy, w_busy_nxt;
    logic                    r_pending;
    logic                    w_start;
    logic                    w_refresh_hit;

    function automatic logic [7:0] f_hex(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    function automatic logic [7:0] f_frame_byte(input logic [3:0] idx,
                                                input logic [15:0] sw,
                                                input logic [7:0] btn);
        logic [7:0] v;
        case (idx)
            4'd0:    v = 8'h53;
            4'd1:    v = f_hex(sw[15:12]);
            4'd2:    v = f_hex(sw[11:8]);
            4'd3:    v = f_hex(sw[7:4]);
            4'd4:    v = f_hex(sw[3:0]);
            4'd5:    v = 8'h42;
            4'd6:    v = f_hex(btn[7:4]);
            4'd7:    v = f_hex(btn[3:0]);
            4'd8:    v = 8'h0D;
            default: v = 8'h0A;
        endcase
        return v;
    endfunction

    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_data_nxt     = r_out_data;
        w_valid_nxt    = r_out_valid;
        w_busy_nxt     = r_busy;
        w_snap_sw_nxt  = r_snap_sw;
        w_snap_btn_nxt = r_snap_btn;
        w_start        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_pending || (r_sw_s2 != r_snap_sw) || (r_btn_s2 != r_snap_btn)) begin
                    w_start        = 1'b1;
                    w_snap_sw_nxt  = r_sw_s2;
                    w_snap_btn_nxt = r_btn_s2;
                    w_idx_nxt      = 4'd0;
                    w_data_nxt     = 8'h53;
                    w_valid_nxt    = 1'b1;
                    w_busy_nxt     = 1'b1;
                    w_state_nxt    = S_SEND;
                end
            end
            default: begin
                if (r_out_valid && out_ready) begin
                    if (r_idx == c_LAST_IDX) begin
                        w_valid_nxt = 1'b0;
                        w_busy_nxt  = 1'b0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_idx_nxt  = r_idx + 4'd1;
                        w_data_nxt = f_frame_byte(r_idx + 4'd1, r_snap_sw,
                                                  {{(8-BUTTON_COUNT){1'b0}}, r_snap_btn});
                    end
                end
            end
        endcase
    end

`ifdef BASYS3_STATUS_REFRESH_EN
    localparam int c_CNT_W = $clog2(REFRESH_CYCLES);
    logic [c_CNT_W-1:0] r_refresh;

    // A frame start restarts the period, so only idle-time silence triggers a resend.
    assign w_refresh_hit = (r_refresh == c_CNT_W'(REFRESH_CYCLES - 1)) && !w_start;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_refresh <= '0;
        end else if (ena) begin
            if (w_start || w_refresh_hit) begin
                r_refresh <= '0;
            end else begin
                r_refresh <= r_refresh + 1'b1;
            end
        end
    end
`else
    assign w_refresh_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_sw_s1     <= '0;
            r_sw_s2     <= '0;
            r_btn_s1    <= '0;
            r_btn_s2    <= '0;
            r_snap_sw   <= '0;
            r_snap_btn  <= '0;
            r_idx       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_pending   <= 1'b1;
        end else if (ena) begin
            r_sw_s1     <= switch_in;
            r_sw_s2     <= r_sw_s1;
            r_btn_s1    <= button_in;
            r_btn_s2    <= r_btn_s1;
            r_state     <= w_state_nxt;
            r_snap_sw   <= w_snap_sw_nxt;
            r_snap_btn  <= w_snap_btn_nxt;
            r_idx       <= w_idx_nxt;
            r_out_data  <= w_data_nxt;
            r_out_valid <= w_valid_nxt;
            r_busy      <= w_busy_nxt;
            if (w_refresh_hit) begin
                r_pending <= 1'b1;
            end else if (w_start) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;

endmodule

`default_nettype wire
